// File: rtl/core_memory_controller.sv
// Memory-side slave for the core data port: turns level-style core requests into
// registered RAM read/write cycles, qualifies ReadOK/WriteOK, and decodes DebugOut.
module core_memory_controller #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned RAM_LATENCY = 1,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic              CoreClock,
  input  logic              CoreResetN,
  input  logic [31:0]       AddressBus,
  input  logic [31:0]       DataWriteBus,
  input  logic              WriteAssert,
  output logic [31:0]       DataReadBus,
  output logic              ReadOK,
  output logic              WriteOK,
  output logic [ADDR_W-1:0] RamAddress,
  output logic              RamReadEnable,
  output logic              RamWriteEnable,
  output logic [31:0]       RamWriteData,
  input  logic [31:0]       RamReadData,
  output logic [31:0]       DebugOut
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_VALID, WR_DONE} state_e;

  localparam int unsigned      CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_LATENCY - 1);

  state_e           state_q, state_d;
  logic [29:0]      latched_q, latched_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      debug_q, debug_d;
  logic             wok_q, wok_d;
  logic             rd_en, wr_en;

  logic [29:0]      word_addr;
  logic             hit_mmio;
  logic             hit_ram;
  logic             addr_same;
  logic             unused_lsb;

  assign word_addr  = AddressBus[31:2];
  assign hit_mmio   = (word_addr == MMIO_BASE[31:2]);
  assign hit_ram    = (AddressBus[31:ADDR_W+2] == '0);
  assign addr_same  = (word_addr == latched_q);
  assign unused_lsb = ^AddressBus[1:0];

  always_comb begin
    state_d   = state_q;
    latched_d = latched_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    debug_d   = debug_q;
    rd_en     = 1'b0;
    wr_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (WriteAssert) begin
          wr_en = hit_ram;
          if (hit_mmio) begin
            debug_d = DataWriteBus;
          end
          state_d = WR_DONE;
        end else begin
          rd_en     = hit_ram;
          latched_d = word_addr;
          cnt_d     = CNT_LOAD;
          state_d   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // Abort outranks capture, so data for a superseded address is never latched.
        if (!addr_same || WriteAssert) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          if (hit_ram) begin
            rdata_d = RamReadData;
          end else if (hit_mmio) begin
            rdata_d = debug_q;
          end else begin
            rdata_d = '0;
          end
          state_d = RD_VALID;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RD_VALID: begin
        if (!addr_same || WriteAssert) begin
          state_d = IDLE;
        end
      end
      WR_DONE: begin
        if (!WriteAssert) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wok_d = (state_d == WR_DONE);
  end

  always_ff @(posedge CoreClock or negedge CoreResetN) begin
    if (!CoreResetN) begin
      state_q   <= IDLE;
      latched_q <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      debug_q   <= '0;
      wok_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      latched_q <= latched_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      debug_q   <= debug_d;
      wok_q     <= wok_d;
    end
  end

  // Strobes come from the IDLE decode, so they are gated while reset holds the FSM there.
  assign RamReadEnable  = rd_en & CoreResetN;
  assign RamWriteEnable = wr_en & CoreResetN;
  assign RamAddress     = AddressBus[ADDR_W+1:2];
  assign RamWriteData   = DataWriteBus;
  assign DataReadBus    = rdata_q;
  assign DebugOut       = debug_q;
  assign WriteOK        = wok_q;
  assign ReadOK         = (state_q == RD_VALID) && addr_same && !WriteAssert;

endmodule

// File: tb/tb_core_memory_controller.sv
// Scoreboard bench for core_memory_controller: stimulus predicts each ReadOK/WriteOK
// response from a word-level memory model; a negedge monitor pops and compares.
module tb_core_memory_controller;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned LAT    = 3;
  localparam logic [31:0] MMIO   = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] AddressBus, DataWriteBus, DataReadBus, RamWriteData, RamReadData, DebugOut;
  logic        WriteAssert, ReadOK, WriteOK, RamReadEnable, RamWriteEnable;
  logic [ADDR_W-1:0] RamAddress;

  core_memory_controller #(
    .ADDR_W(ADDR_W),
    .RAM_LATENCY(LAT),
    .MMIO_BASE(MMIO)
  ) dut (
    .CoreClock(clk),
    .CoreResetN(rst_n),
    .AddressBus(AddressBus),
    .DataWriteBus(DataWriteBus),
    .WriteAssert(WriteAssert),
    .DataReadBus(DataReadBus),
    .ReadOK(ReadOK),
    .WriteOK(WriteOK),
    .RamAddress(RamAddress),
    .RamReadEnable(RamReadEnable),
    .RamWriteEnable(RamWriteEnable),
    .RamWriteData(RamWriteData),
    .RamReadData(RamReadData),
    .DebugOut(DebugOut)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM macro: data is presented only in the single cycle LAT-1 after the enable edge.
  logic [31:0] ram [0:(1<<ADDR_W)-1];
  logic [31:0] pd [LAT];
  logic        pv [LAT];
  int unsigned ram_wr_cnt = 0, ram_rd_cnt = 0;

  initial for (int k = 0; k < LAT; k++) begin pv[k] = 1'b0; pd[k] = '0; end

  always @(posedge clk) begin
    if (RamWriteEnable) begin
      ram[RamAddress] <= RamWriteData;
      ram_wr_cnt <= ram_wr_cnt + 1;
    end
    if (RamReadEnable) ram_rd_cnt <= ram_rd_cnt + 1;
    pd[0] <= ram[RamAddress];
    pv[0] <= RamReadEnable;
    for (int k = 1; k < LAT; k++) begin
      pd[k] <= pd[k-1];
      pv[k] <= pv[k-1];
    end
  end
  assign RamReadData = pv[LAT-1] ? pd[LAT-1] : 32'hBAD0_BAD0;

  // Reference model: word memory plus debug register, addressed by the decode rules.
  logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
  logic [31:0] ref_dbg = '0;
  logic [31:0] exp_drb = '0;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (a[31:2] == MMIO[31:2]) return ref_dbg;
    if (a[31:ADDR_W+2] == '0) return ref_mem[a[ADDR_W+1:2]];
    return 32'h0;
  endfunction

  typedef struct packed {
    logic        is_wr;
    logic [31:0] data;
    logic [31:0] at;
    logic [31:0] len;
  } exp_t;

  exp_t sbq[$];
  int unsigned n_checks = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor
  exp_t        me;
  logic        prev_rok = 1'b0, prev_wok = 1'b0, rd_act = 1'b0, wr_act = 1'b0;
  int unsigned rd_cnt = 0, wr_cnt = 0;
  logic [31:0] rd_len = '0, wr_len = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rok = 1'b0; prev_wok = 1'b0; rd_act = 1'b0; wr_act = 1'b0;
    end else begin
      if (ReadOK && !prev_rok) begin
        if (sbq.size() == 0 || sbq[0].is_wr) begin
          n_checks++; n_fail++;
          $display("FAIL read_unexpected at cycle %0d: got ReadOK=1, expected no read pending", cyc);
        end else begin
          me = sbq.pop_front();
          chk("read_latency", cyc, me.at);
          chk("read_data", DataReadBus, me.data);
          exp_drb = me.data; rd_len = me.len; rd_cnt = 0; rd_act = 1'b1;
        end
      end
      if (ReadOK) rd_cnt++;
      if (!ReadOK && rd_act) begin
        chk("readok_len", rd_cnt, rd_len);
        rd_act = 1'b0;
      end

      if (WriteOK && !prev_wok) begin
        if (sbq.size() == 0 || !sbq[0].is_wr) begin
          n_checks++; n_fail++;
          $display("FAIL write_unexpected at cycle %0d: got WriteOK=1, expected no write pending", cyc);
        end else begin
          me = sbq.pop_front();
          chk("write_latency", cyc, me.at);
          chk("debugout", DebugOut, me.data);
          wr_len = me.len; wr_cnt = 0; wr_act = 1'b1;
        end
      end
      if (WriteOK) wr_cnt++;
      if (!WriteOK && wr_act) begin
        chk("writeok_len", wr_cnt, wr_len);
        wr_act = 1'b0;
      end

      if (ReadOK) chk("readok_stale", DataReadBus, ref_read(AddressBus));
      chk("drb_hold", DataReadBus, exp_drb);
      chk("en_excl", 32'(RamReadEnable & RamWriteEnable), 32'h0);
      if (RamWriteEnable) begin
        chk("we_map", 32'(AddressBus[31:ADDR_W+2] == '0), 32'h1);
        chk("we_data", RamWriteData, DataWriteBus);
      end
      if (RamReadEnable || RamWriteEnable)
        chk("ram_addr", 32'(RamAddress), 32'(AddressBus[ADDR_W+1:2]));
      prev_rok = ReadOK;
      prev_wok = WriteOK;
    end
  end

  // Stimulus
  int unsigned idle_from = 0;
  int unsigned n_wr_exp = 0, n_rd_exp = 0;
  logic        prev_write = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned issue_at(input int unsigned t);
    return (t > idle_from) ? t : idle_from;
  endfunction

  function automatic logic [31:0] pick_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return MMIO | 32'($urandom_range(0, 3));
    if (r == 1) return 32'h0010_0000 | 32'($urandom_range(0, 15) << 2);
    if (r == 2) return 32'h0000_3FFC;
    return 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] fresh(input logic [31:0] a);
    if (!prev_write && a[31:2] == AddressBus[31:2]) return a ^ 32'h4;
    return a;
  endfunction

  task automatic do_read(input logic [31:0] a, input int unsigned hold);
    int unsigned t, i;
    exp_t e;
    AddressBus = a; WriteAssert = 1'b0; DataWriteBus = $urandom;
    t = cyc; i = issue_at(t);
    if (a[31:ADDR_W+2] == '0) n_rd_exp++;
    e.is_wr = 1'b0; e.data = ref_read(a); e.at = i + LAT + 1; e.len = hold;
    sbq.push_back(e);
    repeat (i + LAT + 1 + hold - t) tick();
    idle_from = cyc + 1; prev_write = 1'b0;
  endtask

  task automatic do_read_abort(input logic [31:0] a, input int unsigned k);
    int unsigned t, i;
    AddressBus = a; WriteAssert = 1'b0; DataWriteBus = $urandom;
    t = cyc; i = issue_at(t);
    if (a[31:ADDR_W+2] == '0) n_rd_exp++;
    repeat (i + k - t) tick();
    idle_from = cyc + 1; prev_write = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int unsigned h);
    int unsigned t, i;
    exp_t e;
    if (prev_write) tick();
    AddressBus = a; DataWriteBus = d; WriteAssert = 1'b1;
    t = cyc; i = issue_at(t);
    if (a[31:2] == MMIO[31:2]) ref_dbg = d;
    else if (a[31:ADDR_W+2] == '0) begin
      ref_mem[a[ADDR_W+1:2]] = d;
      n_wr_exp++;
    end
    e.is_wr = 1'b1; e.data = ref_dbg; e.at = i + 1; e.len = h;
    sbq.push_back(e);
    repeat (i + h - t) tick();
    WriteAssert = 1'b0;
    idle_from = cyc + 1; prev_write = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_drb"}, DataReadBus, 32'h0);
    chk({tag, "_readok"}, 32'(ReadOK), 32'h0);
    chk({tag, "_writeok"}, 32'(WriteOK), 32'h0);
    chk({tag, "_debugout"}, DebugOut, 32'h0);
    chk({tag, "_re"}, 32'(RamReadEnable), 32'h0);
    chk({tag, "_we"}, 32'(RamWriteEnable), 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    int unsigned op, t, i;

    AddressBus = 32'h14; DataWriteBus = '0; WriteAssert = 1'b0;
    for (int w = 0; w < (1 << ADDR_W); w++) begin
      ram[w] = $urandom;
      ref_mem[w] = ram[w];
    end
    ram[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1; idle_from = cyc; prev_write = 1'b0;

    // Basic read, write then read-back, mid-read abort.
    do_read(32'h14, 10);
    do_write(32'h40, 32'h0BAD_F00D, 2);
    do_write(32'h14, 32'h1234_5678, 1);
    do_read(32'h14, 3);
    do_read_abort(32'h0, 2);
    do_read(32'h8, 3);

    // MMIO and unmapped space.
    do_write(MMIO, 32'hA5, 1);
    do_read(MMIO, 2);
    do_read(32'h0010_0000, 2);

    // Reset while a RAM read waits on the macro.
    a = fresh(32'h24);
    AddressBus = a; WriteAssert = 1'b0;
    t = cyc; i = issue_at(t);
    n_rd_exp++;
    repeat (i + 2 - t) tick();
    exp_drb = '0; ref_dbg = '0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) tick();
    chk("midrst_re_held", 32'(RamReadEnable), 32'h0);
    rst_n = 1'b1; idle_from = cyc; prev_write = 1'b0;
    do_read(a, 3);

    // Fetch loop.
    do_read(32'h0, 2);
    do_read(32'h4, 2);
    do_read(32'h8, 2);

    // Randomized mix.
    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 9);
      a = pick_addr();
      if (op < 3) do_write(a, $urandom, $urandom_range(1, 3));
      else if (op < 8) do_read(fresh(a), $urandom_range(1, 4));
      else do_read_abort(fresh(a), $urandom_range(1, LAT));
    end

    do_read(fresh(32'h1C), 2);
    repeat (10) tick();
    chk("sb_drain", sbq.size(), 32'h0);
    chk("ram_write_count", ram_wr_cnt, n_wr_exp);
    chk("ram_read_count", ram_rd_cnt, n_rd_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
